load_unit: RTL

//  Read-side companion to the data memory: takes RV32I load requests from the core.

---
 rtl/load_unit.sv | 124 ++++++++++++
 1 files changed

// File: rtl/load_unit.sv
// RV32I load unit: word reads from a combinational data memory, byte/half/word extract and extend.
// Define MISALIGN_TRAP_EN to trap misaligned loads with ld_err instead of splitting them.
module load_unit #(
  parameter int ADDR_W   = 32,
  parameter bit ERR_ZERO = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [2:0]        funct3,
  output logic [ADDR_W-1:0] mem_a,
  input  logic [31:0]       mem_rd,
  output logic              ld_valid,
  output logic [31:0]       rdata,
  output logic              ld_err
);

  // state | meaning
  // IDLE  | ready for a request
  // RD0   | reading the word holding the first byte
  // RD1   | reading the following word of a split access
  // RESP  | result presented with ld_valid
  typedef enum logic [1:0] {IDLE, RD0, RD1, RESP} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        f3_q;
  logic [31:0]       w0, w1, rdata_q;

  logic              f3_ok, misalign, need_rd1, err;
  logic [ADDR_W-1:0] word_a;
  logic [63:0]       pair;
  logic [31:0]       sh, res;

  assign word_a = {addr_q[ADDR_W-1:2], 2'b00};

  always_comb begin
    f3_ok = (f3_q == 3'b000) || (f3_q == 3'b001) || (f3_q == 3'b010) ||
            (f3_q == 3'b100) || (f3_q == 3'b101);
`ifdef MISALIGN_TRAP_EN
    // Halfwords must be naturally aligned when trapping, not just within one word.
    misalign = ((f3_q[1:0] == 2'b01) && addr_q[0]) ||
               ((f3_q == 3'b010) && (addr_q[1:0] != 2'b00));
    need_rd1 = 1'b0;
    err      = !f3_ok || misalign;
`else
    misalign = ((f3_q[1:0] == 2'b01) && (addr_q[1:0] == 2'b11)) ||
               ((f3_q == 3'b010) && (addr_q[1:0] != 2'b00));
    need_rd1 = f3_ok && misalign;
    err      = !f3_ok;
`endif
  end

  always_comb begin
    pair = {w1, w0};
    sh   = 32'(pair >> {addr_q[1:0], 3'b000});
    res  = 32'h0;
    if (err) begin
      res = ERR_ZERO ? 32'h0 : w0;
    end else begin
      case (f3_q)
        3'b000:  res = {{24{sh[7]}}, sh[7:0]};
        3'b001:  res = {{16{sh[15]}}, sh[15:0]};
        3'b010:  res = sh;
        3'b100:  res = {24'h0, sh[7:0]};
        3'b101:  res = {16'h0, sh[15:0]};
        default: res = 32'h0;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    ld_valid  = 1'b0;
    ld_err    = 1'b0;
    mem_a     = '0;
    rdata     = rdata_q;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = RD0;
      end
      RD0: begin
        mem_a     = word_a;
        state_nxt = need_rd1 ? RD1 : RESP;
      end
      RD1: begin
        mem_a     = word_a + ADDR_W'(4);
        state_nxt = RESP;
      end
      RESP: begin
        ld_valid  = 1'b1;
        ld_err    = err;
        rdata     = res;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      addr_q  <= '0;
      f3_q    <= 3'b0;
      w0      <= 32'h0;
      w1      <= 32'h0;
      rdata_q <= 32'h0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && req_valid) begin
        addr_q <= ld_addr;
        f3_q   <= funct3;
      end
      if (state == RD0)  w0      <= mem_rd;
      if (state == RD1)  w1      <= mem_rd;
      if (state == RESP) rdata_q <= res;
    end
  end

endmodule
